obstacle_spawner: RTL and testbench
===================================

OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

Interface
REQ-001 SHALL have parameter NUM_OBS, default 4, meaning obstacle slot count.
REQ-002 SHALL have parameter Y_W, default 10, meaning vertical position width.
REQ-003 SHALL have parameter SCREEN_H, default 480, meaning exit row.
REQ-004 SHALL have parameter BASE_GAP, default 8, meaning minimum ticks between spawn attempts.
REQ-005 SHALL have parameter SPEED, default 2, meaning rows moved per tick.
REQ-006 SHALL have parameter MIN_SEP, default 64, meaning lane-repeat exclusion distance.
REQ-007 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-009 SHALL have port rnd  input  8  pseudo-random byte from upstream LFSR, sampled every cycle.
REQ-010 SHALL have port tick  input  1  one-cycle frame-advance pulse.
REQ-011 SHALL have port enable  input  1  game running; tick ignored when 0.
REQ-012 SHALL have port kill_valid  input  1  request to retire one slot.
REQ-013 SHALL have port kill_idx  input  clog2(NUM_OBS)  slot to retire.
REQ-014 SHALL have port obs_active  output  NUM_OBS  per-slot valid, registered.
REQ-015 SHALL have port obs_lane  output  3*NUM_OBS  per-slot lane 0-7, slot i at [3i+2:3i].
REQ-016 SHALL have port obs_y  output  Y_W*NUM_OBS  per-slot row, slot i at [Y_W*i+Y_W-1:Y_W*i].
REQ-017 SHALL have port spawn_pulse  output  1  one-cycle, successful spawn.
REQ-018 SHALL have port drop_pulse  output  1  one-cycle, spawn attempted with table full.
REQ-019 SHALL have port live_count  output  clog2(NUM_OBS)+1  registered popcount of obs_active.

Function
REQ-020 Advance event SHALL be tick=1 and enable=1 in a cycle; all state changes except kill/reset occur only on advance events, visible the following cycle.
REQ-021 Gap counter SHALL decrement on each advance event when nonzero; when zero, the event SHALL be a spawn attempt and reload gap counter with BASE_GAP + rnd[7:4].
REQ-022 Spawn attempt SHALL select the lowest-index slot with obs_active=0 (pre-event value) and set active=1, y=0, lane per REQ-023; spawn_pulse=1 for exactly one cycle.
REQ-023 Candidate lane SHALL be rnd[2:0]; if it equals the last-spawned lane and that obstacle is still active with y < MIN_SEP, lane SHALL be (rnd[2:0]+1) mod 8.
REQ-024 Spawn attempt with all slots active SHALL leave the table unchanged (motion still applies), pulse drop_pulse one cycle, and still reload the gap counter.
REQ-025 On each advance event every slot active before the event SHALL have y += SPEED; if y+SPEED >= SCREEN_H the slot SHALL become inactive with y=0, lane held.
REQ-026 A slot spawned on an advance event SHALL NOT move on that event.
REQ-027 kill_valid=1 SHALL clear obs_active[kill_idx] and its y next cycle, independent of tick/enable; kill overrides motion for that slot; kill of an inactive slot is a no-op.
REQ-028 A slot killed in a cycle SHALL NOT be selectable for a spawn in the same cycle.
REQ-029 live_count SHALL equal popcount(obs_active) in the same cycle.
REQ-030 enable=0 SHALL freeze gap counter and positions; kills still apply.

Reset
REQ-031 rst=1 SHALL override all inputs: obs_active=0, obs_lane=0, obs_y=0, spawn_pulse=0, drop_pulse=0, live_count=0, gap counter=BASE_GAP, last-spawn record invalid.
REQ-032 Reset asserted mid-operation SHALL discard any spawn, kill or motion in that cycle.

Verification
REQ-033 Reset, enable=1, rnd=8'h35, ticks every 4 cycles -> ticks 1-8 no spawn; tick 9 -> slot0 active, lane 5, y=0, spawn_pulse; next spawn at tick 21 (gap 11+1).
REQ-034 Single slot at y=476, SPEED=2 -> next tick y=478; following tick obs_active[0]=0, y=0, live_count decrements.
REQ-035 All 4 slots active, spawn attempt -> drop_pulse=1, spawn_pulse=0, slots only moved by 2.
REQ-036 Last lane 5 at y=10, rnd[2:0]=5 -> lane 6; last lane 7 at y=10, rnd[2:0]=7 -> lane 0; last lane 5 at y=64, rnd[2:0]=5 -> lane 5.
REQ-037 kill_valid=1, kill_idx=1 coincident with tick -> slot1 inactive next cycle, not moved, not refilled that cycle; enable=0 with ticks -> positions frozen.
REQ-038 rst pulsed while 3 slots active and tick/kill present -> all outputs zero next cycle, first spawn again after 9 ticks.

Source files
------------

// File: rtl/obstacle_spawner.sv
// Obstacle table for a lane game: timed spawns into free slots, downward motion on
// frame ticks, explicit retirement via kill, and lane anti-repeat near the top.
module obstacle_spawner #(
    parameter int NUM_OBS  = 4,
    parameter int Y_W      = 10,
    parameter int SCREEN_H = 480,
    parameter int BASE_GAP = 8,
    parameter int SPEED    = 2,
    parameter int MIN_SEP  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rnd,
    input  logic                       tick,
    input  logic                       enable,
    input  logic                       kill_valid,
    input  logic [$clog2(NUM_OBS)-1:0] kill_idx,
    output logic [NUM_OBS-1:0]         obs_active,
    output logic [3*NUM_OBS-1:0]       obs_lane,
    output logic [Y_W*NUM_OBS-1:0]     obs_y,
    output logic                       spawn_pulse,
    output logic                       drop_pulse,
    output logic [$clog2(NUM_OBS):0]   live_count
);

    localparam int IDX_W = $clog2(NUM_OBS);
    localparam int GAP_W = $clog2(BASE_GAP + 16);

    logic [NUM_OBS-1:0] active_q, active_n;
    logic [2:0]         lane_q [NUM_OBS];
    logic [2:0]         lane_n [NUM_OBS];
    logic [Y_W-1:0]     y_q    [NUM_OBS];
    logic [Y_W-1:0]     y_n    [NUM_OBS];
    logic [GAP_W-1:0]   gap_q, gap_n;
    logic [2:0]         last_lane_q, last_lane_n;
    logic [IDX_W-1:0]   last_idx_q, last_idx_n;
    logic               last_valid_q, last_valid_n;
    logic               spawn_n, drop_n;
    logic [IDX_W:0]     live_n;

    logic               advance;
    logic [NUM_OBS-1:0] kill_mask, free_mask;
    logic               found;
    logic [IDX_W-1:0]   sel;
    logic [2:0]         cand_lane;
    logic [Y_W:0]       ysum;
    logic               unused_rnd;

    assign unused_rnd = rnd[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q     <= '0;
            lane_q       <= '{default: '0};
            y_q          <= '{default: '0};
            gap_q        <= GAP_W'(BASE_GAP);
            last_lane_q  <= '0;
            last_idx_q   <= '0;
            last_valid_q <= 1'b0;
            spawn_pulse  <= 1'b0;
            drop_pulse   <= 1'b0;
            live_count   <= '0;
        end else begin
            active_q     <= active_n;
            lane_q       <= lane_n;
            y_q          <= y_n;
            gap_q        <= gap_n;
            last_lane_q  <= last_lane_n;
            last_idx_q   <= last_idx_n;
            last_valid_q <= last_valid_n;
            spawn_pulse  <= spawn_n;
            drop_pulse   <= drop_n;
            live_count   <= live_n;
        end
    end

    // Slot selection uses pre-event occupancy; a slot killed this cycle is masked out.
    always_comb begin
        advance   = tick & enable;
        kill_mask = '0;
        found     = 1'b0;
        sel       = '0;
        for (int unsigned i = 0; i < NUM_OBS; i++) begin
            if (kill_valid && (IDX_W'(i) == kill_idx)) kill_mask[i] = 1'b1;
        end
        free_mask = ~active_q & ~kill_mask;
        for (int unsigned i = 0; i < NUM_OBS; i++) begin
            if (free_mask[i] && !found) begin
                found = 1'b1;
                sel   = IDX_W'(i);
            end
        end
        cand_lane = rnd[2:0];
        if (last_valid_q && (rnd[2:0] == last_lane_q) && active_q[last_idx_q]
            && (y_q[last_idx_q] < Y_W'(MIN_SEP)))
            cand_lane = rnd[2:0] + 3'd1;
    end

    always_comb begin
        active_n     = active_q;
        lane_n       = lane_q;
        y_n          = y_q;
        gap_n        = gap_q;
        last_lane_n  = last_lane_q;
        last_idx_n   = last_idx_q;
        last_valid_n = last_valid_q;
        spawn_n      = 1'b0;
        drop_n       = 1'b0;
        ysum         = '0;
        if (advance) begin
            for (int unsigned i = 0; i < NUM_OBS; i++) begin
                if (active_q[i]) begin
                    ysum = {1'b0, y_q[i]} + (Y_W+1)'(SPEED);
                    if (ysum >= (Y_W+1)'(SCREEN_H)) begin
                        active_n[i] = 1'b0;
                        y_n[i]      = '0;
                    end else begin
                        y_n[i] = ysum[Y_W-1:0];
                    end
                end
            end
            if (gap_q != '0) begin
                gap_n = gap_q - GAP_W'(1);
            end else begin
                gap_n = GAP_W'(BASE_GAP) + GAP_W'(rnd[7:4]);
                if (found) begin
                    active_n[sel] = 1'b1;
                    y_n[sel]      = '0;
                    lane_n[sel]   = cand_lane;
                    last_lane_n   = cand_lane;
                    last_idx_n    = sel;
                    last_valid_n  = 1'b1;
                    spawn_n       = 1'b1;
                end else begin
                    drop_n = 1'b1;
                end
            end
        end
        for (int unsigned i = 0; i < NUM_OBS; i++) begin
            if (kill_mask[i]) begin
                active_n[i] = 1'b0;
                y_n[i]      = '0;
            end
        end
    end

    always_comb begin
        live_n = '0;
        for (int unsigned i = 0; i < NUM_OBS; i++)
            live_n = live_n + (IDX_W+1)'(active_n[i]);
    end

    always_comb begin
        obs_active = active_q;
        obs_lane   = '0;
        obs_y      = '0;
        for (int unsigned i = 0; i < NUM_OBS; i++) begin
            obs_lane[3*i +: 3]   = lane_q[i];
            obs_y[Y_W*i +: Y_W]  = y_q[i];
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner: a per-cycle vector table followed by
// hand-computed multi-cycle scenarios (spawn timing, exit, full table, lanes, kill, reset).
module tb_obstacle_spawner;

    logic        clk = 1'b0;
    logic        rst, tick, enable, kill_valid;
    logic [7:0]  rnd;
    logic [1:0]  kill_idx;
    logic [3:0]  obs_active;
    logic [11:0] obs_lane;
    logic [39:0] obs_y;
    logic        spawn_pulse, drop_pulse;
    logic [2:0]  live_count;

    int vecs = 0;
    int errs = 0;

    obstacle_spawner #(
        .NUM_OBS(4), .Y_W(10), .SCREEN_H(480), .BASE_GAP(8), .SPEED(2), .MIN_SEP(64)
    ) dut (
        .clk(clk), .rst(rst), .rnd(rnd), .tick(tick), .enable(enable),
        .kill_valid(kill_valid), .kill_idx(kill_idx),
        .obs_active(obs_active), .obs_lane(obs_lane), .obs_y(obs_y),
        .spawn_pulse(spawn_pulse), .drop_pulse(drop_pulse), .live_count(live_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, tick, en, kv;
        logic [1:0]  ki;
        logic [7:0]  rnd;
        logic [3:0]  act;
        logic [11:0] lane;
        logic [39:0] y;
        logic        sp, dr;
        logic [2:0]  live;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, t, e, kv, input logic [1:0] ki, input logic [7:0] rn,
                       input logic [3:0] act, input logic [11:0] ln, input logic [39:0] y,
                       input logic sp, dr, input logic [2:0] live);
        vec_t v;
        v.rst = r; v.tick = t; v.en = e; v.kv = kv; v.ki = ki; v.rnd = rn;
        v.act = act; v.lane = ln; v.y = y; v.sp = sp; v.dr = dr; v.live = live;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        tick = 1'b1; enable = 1'b1;
        for (int k = 0; k < n; k++) step();
        tick = 1'b0;
    endtask

    task automatic do_reset(input logic [7:0] r);
        rst = 1'b1; tick = 1'b0; enable = 1'b1; kill_valid = 1'b0; kill_idx = 2'd0; rnd = r;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; enable = 1'b0; kill_valid = 1'b0; kill_idx = 2'd0; rnd = 8'h35;

        // Per-cycle table, rnd=8'h35 (lane 5, reload 11)
        add(1, 0, 1, 0, 0, 8'h35, 4'h0, 12'h000, 40'd0, 0, 0, 3'd0);
        add(0, 0, 1, 0, 0, 8'h35, 4'h0, 12'h000, 40'd0, 0, 0, 3'd0);
        add(0, 1, 0, 0, 0, 8'h35, 4'h0, 12'h000, 40'd0, 0, 0, 3'd0);
        for (int i = 0; i < 8; i++)
            add(0, 1, 1, 0, 0, 8'h35, 4'h0, 12'h000, 40'd0, 0, 0, 3'd0);
        add(0, 1, 1, 0, 0, 8'h35, 4'h1, 12'h005, 40'd0, 1, 0, 3'd1);
        add(0, 0, 1, 0, 0, 8'h35, 4'h1, 12'h005, 40'd0, 0, 0, 3'd1);
        add(0, 1, 1, 0, 0, 8'h35, 4'h1, 12'h005, 40'd2, 0, 0, 3'd1);
        add(0, 1, 0, 0, 0, 8'h35, 4'h1, 12'h005, 40'd2, 0, 0, 3'd1);
        add(0, 1, 1, 0, 0, 8'h35, 4'h1, 12'h005, 40'd4, 0, 0, 3'd1);
        add(0, 0, 1, 1, 0, 8'h35, 4'h0, 12'h005, 40'd0, 0, 0, 3'd0);
        add(0, 0, 1, 1, 2, 8'h35, 4'h0, 12'h005, 40'd0, 0, 0, 3'd0);
        add(1, 1, 1, 1, 1, 8'h35, 4'h0, 12'h000, 40'd0, 0, 0, 3'd0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; tick = tbl[i].tick; enable = tbl[i].en;
            kill_valid = tbl[i].kv; kill_idx = tbl[i].ki; rnd = tbl[i].rnd;
            step();
            chk($sformatf("v%0d active", i), 64'(obs_active), 64'(tbl[i].act));
            chk($sformatf("v%0d lane", i), 64'(obs_lane), 64'(tbl[i].lane));
            chk($sformatf("v%0d y", i), 64'(obs_y), 64'(tbl[i].y));
            chk($sformatf("v%0d spawn", i), 64'(spawn_pulse), 64'(tbl[i].sp));
            chk($sformatf("v%0d drop", i), 64'(drop_pulse), 64'(tbl[i].dr));
            chk($sformatf("v%0d live", i), 64'(live_count), 64'(tbl[i].live));
        end
        kill_valid = 1'b0;

        // Ticks every 4 cycles: spawns only on ticks 9 and 21
        do_reset(8'h35);
        for (int t = 1; t <= 21; t++) begin
            tick = 1'b1; enable = 1'b1;
            step();
            tick = 1'b0;
            chk($sformatf("gap t%0d spawn", t), 64'(spawn_pulse), 64'((t == 9) || (t == 21)));
            repeat (3) step();
        end
        chk("gap2 lanes", 64'(obs_lane), 64'h035);
        chk("gap2 y0", 64'(obs_y[9:0]), 64'd24);
        chk("gap2 live", 64'(live_count), 64'd2);

        // Fill, drop with motion, then exit of slot 0; rnd=8'h05 gives a 9-tick cadence
        do_reset(8'h05);
        adv(44);
        chk("fill active", 64'(obs_active), 64'hF);
        chk("fill lanes", 64'(obs_lane), 64'hD75);
        chk("fill y", 64'(obs_y), 64'({10'd16, 10'd34, 10'd52, 10'd70}));
        adv(1);
        chk("full drop", 64'(drop_pulse), 64'd1);
        chk("full spawn", 64'(spawn_pulse), 64'd0);
        chk("full y", 64'(obs_y), 64'({10'd18, 10'd36, 10'd54, 10'd72}));
        adv(202);
        chk("exit y476", 64'(obs_y[9:0]), 64'd476);
        adv(1);
        chk("exit y478", 64'(obs_y[9:0]), 64'd478);
        chk("exit live4", 64'(live_count), 64'd4);
        adv(1);
        chk("exit active", 64'(obs_active), 64'hE);
        chk("exit y0", 64'(obs_y[9:0]), 64'd0);
        chk("exit live3", 64'(live_count), 64'd3);
        chk("exit lane held", 64'(obs_lane[2:0]), 64'd5);

        // Last lane 7 still near top: 7 wraps to 0
        do_reset(8'h07);
        adv(18);
        chk("wrap active", 64'(obs_active), 64'h3);
        chk("wrap lanes", 64'(obs_lane), 64'h007);

        // Last spawned at y=64 exactly: no lane bump
        do_reset(8'h05);
        adv(35);
        rnd = 8'h65;
        adv(1);
        chk("sep spawn36", 64'(spawn_pulse), 64'd1);
        chk("sep lanes36", 64'(obs_lane), 64'hD75);
        adv(14);
        rnd = 8'h96;
        adv(1);
        chk("sep drop51", 64'(drop_pulse), 64'd1);
        kill_valid = 1'b1; kill_idx = 2'd0;
        step();
        chk("kill0 active", 64'(obs_active), 64'hE);
        chk("kill0 y", 64'(obs_y[9:0]), 64'd0);
        chk("kill0 lane held", 64'(obs_lane), 64'hD75);
        step();
        chk("kill0 again", 64'(obs_active), 64'hE);
        chk("kill0 again live", 64'(live_count), 64'd3);
        kill_valid = 1'b0;
        rnd = 8'h06;
        adv(17);
        chk("sep no spawn68", 64'(obs_active), 64'hE);
        adv(1);
        chk("sep spawn69", 64'(spawn_pulse), 64'd1);
        chk("sep lanes69", 64'(obs_lane), 64'hD76);
        chk("sep y3", 64'(obs_y[39:30]), 64'd66);

        // Kill coincident with a spawn attempt, then enable=0 freeze
        do_reset(8'h05);
        adv(44);
        kill_valid = 1'b1; kill_idx = 2'd1;
        adv(1);
        kill_valid = 1'b0;
        chk("kt active", 64'(obs_active), 64'hD);
        chk("kt y", 64'(obs_y), 64'({10'd18, 10'd36, 10'd0, 10'd72}));
        chk("kt drop", 64'(drop_pulse), 64'd1);
        chk("kt spawn", 64'(spawn_pulse), 64'd0);
        chk("kt live", 64'(live_count), 64'd3);
        tick = 1'b1; enable = 1'b0;
        repeat (5) step();
        tick = 1'b0; enable = 1'b1;
        chk("freeze y", 64'(obs_y), 64'({10'd18, 10'd36, 10'd0, 10'd72}));
        chk("freeze drop", 64'(drop_pulse), 64'd0);
        adv(9);
        chk("refill active", 64'(obs_active), 64'hF);
        chk("refill spawn", 64'(spawn_pulse), 64'd1);
        chk("refill lanes", 64'(obs_lane), 64'hD6D);
        chk("refill y0", 64'(obs_y[9:0]), 64'd90);

        // Reset mid-operation with tick and kill present
        do_reset(8'h05);
        adv(30);
        chk("pre-rst live", 64'(live_count), 64'd3);
        rst = 1'b1; tick = 1'b1; enable = 1'b1; kill_valid = 1'b1; kill_idx = 2'd0;
        step();
        rst = 1'b0; tick = 1'b0; kill_valid = 1'b0;
        chk("rst active", 64'(obs_active), 64'h0);
        chk("rst lane", 64'(obs_lane), 64'h0);
        chk("rst y", 64'(obs_y), 64'h0);
        chk("rst live", 64'(live_count), 64'd0);
        chk("rst pulses", 64'({spawn_pulse, drop_pulse}), 64'd0);
        adv(8);
        chk("rst 8 ticks", 64'(obs_active), 64'h0);
        adv(1);
        chk("rst 9th spawn", 64'(spawn_pulse), 64'd1);
        chk("rst 9th active", 64'(obs_active), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
